mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one synchronous `Memory` instance (1-cycle registered read, byte-lane widths 1/2/4) between the CPU32 instruction-fetch port and data port. Lets a single unified memory replace the separate program and data memories. Arbitrates requests, enforces alignment, and routes each read response back to the requester that issued it.

## Interface
- `MAX_DM_STREAK`, default 4: consecutive data grants allowed while fetch is waiting; legal range 1–15.
- `clock` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `im_req` in 1: fetch request; address held stable until granted.
- `im_addr` in 32: fetch byte address; width is always 4.
- `im_ready` out 1: fetch request granted this cycle (combinational).
- `im_rvalid` out 1: fetch response valid.
- `im_rdata` out 32: fetch data; 0 when `im_rvalid`=0.
- `im_err` out 1: misaligned fetch; qualified by `im_rvalid`.
- `dm_req` in 1: data request; all dm inputs held stable until granted.
- `dm_addr` in 32: data byte address.
- `dm_width` in 4: access width, 1, 2 or 4.
- `dm_write` in 1: 1 = store, 0 = load.
- `dm_wdata` in 32: store data, right-aligned.
- `dm_ready` out 1: data request granted this cycle (combinational).
- `dm_rvalid` out 1: data response valid, for loads and stores.
- `dm_rdata` out 32: load data; 0 for stores, errors and idle cycles.
- `dm_err` out 1: misaligned or illegal-width data access.
- `mem_address` out 32: address to the memory.
- `mem_width` out 4: width to the memory; 0 when no access.
- `mem_write_en` out 1: memory write strobe.
- `mem_data_in` out 32: memory write data.
- `mem_data_out` in 32: memory read data; valid one cycle after issue.

## Operation
- **Grant rule**, evaluated combinationally every cycle:
  - Only `dm_req`: grant dm.
  - Only `im_req`: grant im.
  - Both: grant dm, unless `streak == MAX_DM_STREAK`, in which case grant im.
- **Streak counter** (4-bit):
  - Increments on each dm grant made while `im_req`=1.
  - Clears on any im grant, and on any cycle with `im_req`=0.
  - Saturates at `MAX_DM_STREAK`.
- **One grant per cycle.** A new grant is allowed every cycle; the memory is fully pipelined.
- **Legality check on the granted request:**
  - width 1: always legal.
  - width 2: requires `addr[0]`=0.
  - width 4: requires `addr[1:0]`=0.
  - Any other width is illegal.
  - im is always width 4.
- **Legal grant:** drive `mem_address`=addr and `mem_width`=width. For a dm store, also drive `mem_write_en`=1 and `mem_data_in`=`dm_wdata`.
- **Illegal grant:** `mem_width`=0 and `mem_write_en`=0, so memory contents are unchanged. The request is still consumed (ready=1) and an error response is produced.
- **No grant:** `mem_width`=0, `mem_write_en`=0, `mem_address`=0, `mem_data_in`=0.
- **Response tracking** uses three registers: `resp_owner` (none/im/dm), `resp_err`, and `resp_store`, loaded at each grant.
  - Next cycle, the owner's rvalid=1 and err=`resp_err`.
  - rdata=`mem_data_out`, except 0 if `resp_err` or `resp_store`.
  - The non-owner's outputs are all 0.
- **Reset:** registers clear and outputs take these values:
  - `resp_owner`=none, streak=0.
  - `im_ready`=`dm_ready`=0 while `reset`=1.
  - All rvalid/err/rdata outputs are 0.
  - `mem_width`=0, `mem_write_en`=0.
  - A response in flight when reset asserts is dropped and never presented.

## Timing
- Grant in cycle t gives response in cycle t+1 (latency 1). The response appears for exactly one cycle, with no backpressure on responses.
- Memory interface signals are combinational from the request inputs and the streak register. The memory samples them at the edge ending cycle t.
- A store writes at the edge ending cycle t. A dm load granted in t+1 to the same address returns the new data in t+2.
- Simultaneous grant and response:
  - A grant in cycle t+1 coexists with the response of cycle t's grant.
  - Back-to-back grants to the same requester yield rvalid high on consecutive cycles.
- Requester dropping req before ready: no transaction occurs, and the streak still follows the rules above.
- Reset asserted in cycle t: no grant in t, and no response in t+1.

## Test plan
- **Fetch alone:** mem word 0x10 = 0x00400513. Assert `im_req` with `im_addr`=0x10 → `im_ready`=1 in t; `im_rvalid`=1 and `im_rdata`=0x00400513 in t+1; `dm_rvalid`=0.
- **Contention with streak** (`MAX_DM_STREAK`=4): hold `im_req`=1 and `dm_req`=1 for 10 cycles → grant order dm,dm,dm,dm,im,dm,dm,dm,dm,im; responses are routed to the matching port one cycle later.
- **Store then load:**
  - `sw` 0xDEADBEEF to 0x40 (width 4).
  - Then `lb` width 1 at 0x41 → `dm_rdata`=0x000000BE.
  - Then width 2 at 0x42 → `dm_rdata`=0x0000DEAD.
- **Misaligned store:** width 4 at 0x42 with data 0x12345678 → `dm_ready`=1, `mem_write_en`=0; next cycle `dm_rvalid`=1, `dm_err`=1, `dm_rdata`=0; a following load of 0x40 still returns 0xDEADBEEF. Repeat with width 3 → `dm_err`=1.
- **Reset mid-flight:** grant a dm load at 0x40 in cycle t, assert `reset` in t+1 → `dm_rvalid`=0 in t+1 and t+2; all outputs at reset values; streak=0, confirmed by the dm-first order resuming after release.
- **Idle:** no requests for 5 cycles → `mem_width`=0, `mem_write_en`=0, and all rvalid, err and rdata outputs = 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one pipelined memory between the CPU32 fetch and data ports: picks one
// request per cycle, screens alignment, and steers the next-cycle response home.
module mem_port_arbiter #(
    parameter int MAX_DM_STREAK = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        im_req,
    input  logic [31:0] im_addr,
    output logic        im_ready,
    output logic        im_rvalid,
    output logic [31:0] im_rdata,
    output logic        im_err,
    input  logic        dm_req,
    input  logic [31:0] dm_addr,
    input  logic [3:0]  dm_width,
    input  logic        dm_write,
    input  logic [31:0] dm_wdata,
    output logic        dm_ready,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,
    output logic        dm_err,
    output logic [31:0] mem_address,
    output logic [3:0]  mem_width,
    output logic        mem_write_en,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_IM   = 2'd1,
        OWNER_DM   = 2'd2
    } owner_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);

    owner_t     resp_owner, resp_owner_next;
    logic       resp_err, resp_err_next;
    logic       resp_store, resp_store_next;
    logic [3:0] streak, streak_next;
    logic       grant_dm, grant_im;
    logic       im_legal, dm_legal;

    // Data wins ties until it has starved fetch for MAX_DM_STREAK grants.
    always_comb begin
        grant_dm = !reset && dm_req && (!im_req || (streak != STREAK_MAX));
        grant_im = !reset && im_req && !grant_dm;
    end

    always_comb begin
        im_legal = (im_addr[1:0] == 2'b00);
        case (dm_width)
            4'd1:    dm_legal = 1'b1;
            4'd2:    dm_legal = !dm_addr[0];
            4'd4:    dm_legal = (dm_addr[1:0] == 2'b00);
            default: dm_legal = 1'b0;
        endcase
    end

    assign im_ready = grant_im;
    assign dm_ready = grant_dm;

    always_comb begin
        streak_next = streak;
        if (!im_req || grant_im) begin
            streak_next = 4'd0;
        end else if (grant_dm && (streak != STREAK_MAX)) begin
            streak_next = streak + 4'd1;
        end
    end

    // An illegal grant still presents its address but a zero width, so the memory ignores it.
    always_comb begin
        mem_address  = 32'h0;
        mem_width    = 4'd0;
        mem_write_en = 1'b0;
        mem_data_in  = 32'h0;
        if (grant_dm) begin
            mem_address = dm_addr;
            if (dm_legal) begin
                mem_width = dm_width;
                if (dm_write) begin
                    mem_write_en = 1'b1;
                    mem_data_in  = dm_wdata;
                end
            end
        end else if (grant_im) begin
            mem_address = im_addr;
            if (im_legal) begin
                mem_width = 4'd4;
            end
        end
    end

    always_comb begin
        resp_owner_next = OWNER_NONE;
        resp_err_next   = 1'b0;
        resp_store_next = 1'b0;
        if (grant_dm) begin
            resp_owner_next = OWNER_DM;
            resp_err_next   = !dm_legal;
            resp_store_next = dm_write;
        end else if (grant_im) begin
            resp_owner_next = OWNER_IM;
            resp_err_next   = !im_legal;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            resp_owner <= OWNER_NONE;
            resp_err   <= 1'b0;
            resp_store <= 1'b0;
            streak     <= 4'd0;
        end else begin
            resp_owner <= resp_owner_next;
            resp_err   <= resp_err_next;
            resp_store <= resp_store_next;
            streak     <= streak_next;
        end
    end

    // Gating with reset drops a response that was in flight when reset arrived.
    always_comb begin
        im_rvalid = !reset && (resp_owner == OWNER_IM);
        dm_rvalid = !reset && (resp_owner == OWNER_DM);
        im_err    = im_rvalid && resp_err;
        dm_err    = dm_rvalid && resp_err;
        im_rdata  = 32'h0;
        dm_rdata  = 32'h0;
        if (im_rvalid && !resp_err) begin
            im_rdata = mem_data_out;
        end
        if (dm_rvalid && !resp_err && !resp_store) begin
            dm_rdata = mem_data_out;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a little-endian byte memory model
// standing in for the shared memory.
module tb_mem_port_arbiter;

    logic        clock;
    logic        reset;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ready, im_rvalid, im_err;
    logic [31:0] im_rdata;
    logic        dm_req;
    logic [31:0] dm_addr;
    logic [3:0]  dm_width;
    logic        dm_write;
    logic [31:0] dm_wdata;
    logic        dm_ready, dm_rvalid, dm_err;
    logic [31:0] dm_rdata;
    logic [31:0] mem_address;
    logic [3:0]  mem_width;
    logic        mem_write_en;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;

    int test_count = 0;
    int fail_count = 0;

    logic [7:0] mem_bytes [0:255];

    mem_port_arbiter #(.MAX_DM_STREAK(4)) dut (
        .clock(clock), .reset(reset),
        .im_req(im_req), .im_addr(im_addr), .im_ready(im_ready),
        .im_rvalid(im_rvalid), .im_rdata(im_rdata), .im_err(im_err),
        .dm_req(dm_req), .dm_addr(dm_addr), .dm_width(dm_width),
        .dm_write(dm_write), .dm_wdata(dm_wdata), .dm_ready(dm_ready),
        .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_err(dm_err),
        .mem_address(mem_address), .mem_width(mem_width),
        .mem_write_en(mem_write_en), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] readMem(input logic [7:0] a, input logic [3:0] w);
        logic [31:0] r;
        r = 32'h0;
        for (int b = 0; b < 4; b++) begin
            if (b < int'(w)) r[8*b +: 8] = mem_bytes[a + 8'(b)];
        end
        return r;
    endfunction

    // Registered read of the old contents; stores land at the same edge.
    always @(posedge clock) begin
        if (mem_width != 4'd0) begin
            mem_data_out <= readMem(mem_address[7:0], mem_width);
            if (mem_write_en) begin
                for (int b = 0; b < 4; b++) begin
                    if (b < int'(mem_width))
                        mem_bytes[mem_address[7:0] + 8'(b)] <= mem_data_in[8*b +: 8];
                end
            end
        end else begin
            mem_data_out <= 32'h0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        test_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ir, input logic [31:0] ia,
                                 input logic dr, input logic [31:0] da, input logic [3:0] dw,
                                 input logic dwr, input logic [31:0] dwd);
        im_req   = ir;
        im_addr  = ia;
        dm_req   = dr;
        dm_addr  = da;
        dm_width = dw;
        dm_write = dwr;
        dm_wdata = dwd;
        #1;
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'd0, 1'b0, 32'h0);
    endtask

    logic [9:0] order10;
    logic [4:0] order5;

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'd0, 1'b0, 32'h0);
        tick;
        tick;

        // Requests during reset must not be granted.
        applyStimulus(1'b1, 32'h10, 1'b1, 32'h40, 4'd4, 1'b1, 32'h1);
        checkOutput("rst_im_ready", im_ready, 1'b0);
        checkOutput("rst_dm_ready", dm_ready, 1'b0);
        checkOutput("rst_mem_width", mem_width, 4'd0);
        checkOutput("rst_mem_we", mem_write_en, 1'b0);
        checkOutput("rst_rvalid", {im_rvalid, dm_rvalid, im_err, dm_err}, 4'd0);

        tick;
        reset = 1'b0;
        idle;
        for (int i = 0; i < 5; i++) begin
            tick;
            checkOutput("idle_mem_width", mem_width, 4'd0);
            checkOutput("idle_mem_we", mem_write_en, 1'b0);
            checkOutput("idle_mem_addr", mem_address, 32'h0);
            checkOutput("idle_flags", {im_rvalid, dm_rvalid, im_err, dm_err}, 4'd0);
            checkOutput("idle_rdata", im_rdata | dm_rdata, 32'h0);
        end

        // Seed the instruction word through the data port.
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h10, 4'd4, 1'b1, 32'h00400513);
        checkOutput("seed_dm_ready", dm_ready, 1'b1);
        checkOutput("seed_mem_we", mem_write_en, 1'b1);
        checkOutput("seed_mem_width", mem_width, 4'd4);
        checkOutput("seed_mem_addr", mem_address, 32'h10);
        checkOutput("seed_mem_din", mem_data_in, 32'h00400513);
        tick;
        idle;
        checkOutput("seed_dm_rvalid", dm_rvalid, 1'b1);
        checkOutput("seed_dm_err", dm_err, 1'b0);
        checkOutput("seed_dm_rdata", dm_rdata, 32'h0);
        tick;

        applyStimulus(1'b1, 32'h10, 1'b0, 32'h0, 4'd0, 1'b0, 32'h0);
        checkOutput("fetch_im_ready", im_ready, 1'b1);
        checkOutput("fetch_dm_ready", dm_ready, 1'b0);
        checkOutput("fetch_mem_width", mem_width, 4'd4);
        checkOutput("fetch_mem_we", mem_write_en, 1'b0);
        tick;
        idle;
        checkOutput("fetch_im_rvalid", im_rvalid, 1'b1);
        checkOutput("fetch_im_rdata", im_rdata, 32'h00400513);
        checkOutput("fetch_im_err", im_err, 1'b0);
        checkOutput("fetch_dm_rvalid", dm_rvalid, 1'b0);
        tick;

        applyStimulus(1'b1, 32'h12, 1'b0, 32'h0, 4'd0, 1'b0, 32'h0);
        checkOutput("badfetch_im_ready", im_ready, 1'b1);
        checkOutput("badfetch_mem_width", mem_width, 4'd0);
        tick;
        idle;
        checkOutput("badfetch_im_rvalid", im_rvalid, 1'b1);
        checkOutput("badfetch_im_err", im_err, 1'b1);
        checkOutput("badfetch_im_rdata", im_rdata, 32'h0);
        tick;

        // Store then immediately dependent loads, back to back.
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h40, 4'd4, 1'b1, 32'hDEADBEEF);
        checkOutput("sw_mem_we", mem_write_en, 1'b1);
        tick;
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h41, 4'd1, 1'b0, 32'h0);
        checkOutput("sw_dm_rvalid", dm_rvalid, 1'b1);
        checkOutput("sw_dm_rdata", dm_rdata, 32'h0);
        checkOutput("lb_mem_width", mem_width, 4'd1);
        tick;
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h42, 4'd2, 1'b0, 32'h0);
        checkOutput("lb_dm_rvalid", dm_rvalid, 1'b1);
        checkOutput("lb_dm_rdata", dm_rdata, 32'h000000BE);
        tick;
        idle;
        checkOutput("lh_dm_rvalid", dm_rvalid, 1'b1);
        checkOutput("lh_dm_rdata", dm_rdata, 32'h0000DEAD);
        tick;

        applyStimulus(1'b0, 32'h0, 1'b1, 32'h42, 4'd4, 1'b1, 32'h12345678);
        checkOutput("missw_dm_ready", dm_ready, 1'b1);
        checkOutput("missw_mem_we", mem_write_en, 1'b0);
        checkOutput("missw_mem_width", mem_width, 4'd0);
        tick;
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h40, 4'd3, 1'b1, 32'h00000055);
        checkOutput("missw_dm_rvalid", dm_rvalid, 1'b1);
        checkOutput("missw_dm_err", dm_err, 1'b1);
        checkOutput("missw_dm_rdata", dm_rdata, 32'h0);
        checkOutput("w3_dm_ready", dm_ready, 1'b1);
        checkOutput("w3_mem_we", mem_write_en, 1'b0);
        tick;
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h40, 4'd4, 1'b0, 32'h0);
        checkOutput("w3_dm_err", dm_err, 1'b1);
        checkOutput("w3_dm_rdata", dm_rdata, 32'h0);
        tick;
        idle;
        checkOutput("reload_dm_rdata", dm_rdata, 32'hDEADBEEF);
        checkOutput("reload_dm_err", dm_err, 1'b0);
        tick;

        // Contention: four data grants, then fetch gets its turn.
        order10 = 10'b0111101111;
        applyStimulus(1'b1, 32'h10, 1'b1, 32'h40, 4'd4, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            checkOutput("cont_dm_ready", dm_ready, order10[i]);
            checkOutput("cont_im_ready", im_ready, !order10[i]);
            if (i > 0) begin
                checkOutput("cont_dm_rvalid", dm_rvalid, order10[i-1]);
                checkOutput("cont_im_rvalid", im_rvalid, !order10[i-1]);
                if (order10[i-1]) checkOutput("cont_dm_rdata", dm_rdata, 32'hDEADBEEF);
                else              checkOutput("cont_im_rdata", im_rdata, 32'h00400513);
            end
            tick;
        end
        idle;
        checkOutput("cont_last_im_rvalid", im_rvalid, 1'b1);
        checkOutput("cont_last_im_rdata", im_rdata, 32'h00400513);
        checkOutput("cont_last_dm_rvalid", dm_rvalid, 1'b0);
        tick;

        // Build a streak of three, then reset with a load in flight.
        applyStimulus(1'b1, 32'h10, 1'b1, 32'h40, 4'd4, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("pre_dm_ready", dm_ready, 1'b1);
            if (i < 2) tick;
        end
        tick;
        reset = 1'b1;
        #1;
        checkOutput("mid_dm_rvalid", dm_rvalid, 1'b0);
        checkOutput("mid_dm_rdata", dm_rdata, 32'h0);
        checkOutput("mid_dm_ready", dm_ready, 1'b0);
        checkOutput("mid_im_ready", im_ready, 1'b0);
        checkOutput("mid_mem_width", mem_width, 4'd0);
        checkOutput("mid_mem_we", mem_write_en, 1'b0);
        tick;
        reset = 1'b0;
        #1;
        checkOutput("post_dm_rvalid", dm_rvalid, 1'b0);
        checkOutput("post_im_rvalid", im_rvalid, 1'b0);
        order5 = 5'b01111;
        for (int i = 0; i < 5; i++) begin
            checkOutput("post_dm_ready", dm_ready, order5[i]);
            checkOutput("post_im_ready", im_ready, !order5[i]);
            tick;
        end
        idle;
        tick;

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
